ble_cmd_receiver: RTL

//  Downstream consumer of the UART RX FIFO while the connection monitor reports S_CONNECTED.

---
 rtl/ble_cmd_receiver.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ble_cmd_receiver.sv
// BLE command frame receiver: hunts SOF, assembles big-endian commands,
// stages them, releases on valid/ready once the frame is good. Option: BLE_CMD_RX_CHKSUM_EN.
module ble_cmd_receiver #(
  parameter int         CMD_WIDTH      = 16,
  parameter int         CMD_DEPTH      = 3,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 260_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  output logic                 rx_rd_en,
  output logic [CMD_WIDTH-1:0] cmd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_last,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [1:0]           err_code
);

  localparam int NB  = CMD_WIDTH / 8;
  localparam int BCW = $clog2(CMD_DEPTH * NB + 1);
  localparam int LW  = $clog2(CMD_DEPTH + 1);
  localparam int SW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic                 pop_q;
  logic [LW-1:0]        len_q;
  logic [CMD_WIDTH-1:0] asm_q;
  logic [BCW-1:0]       bcnt_q;
  logic [SW-1:0]        sub_q;
  logic [LW-1:0]        wr_q;
  logic [LW-1:0]        rd_q;
  logic [LW-1:0]        n_q;
  logic [TW-1:0]        tcnt_q;
  logic [CMD_WIDTH-1:0] stage [CMD_DEPTH];
`ifdef BLE_CMD_RX_CHKSUM_EN
  logic [7:0]           chk_q;
`endif

  logic                   active;
  logic                   tmo;
  logic                   accept;
  logic                   pop;
  logic                   len_bad;
  logic [BCW-1:0]         tot_bytes;
  logic                   last_byte;
  logic                   last_entry;
  logic                   xfer;
  logic [CMD_WIDTH+7:0]   asm_cat;
  logic [CMD_WIDTH-1:0]   asm_nx;
  logic                   ok_ev;
  logic                   err_ev;
  logic [1:0]             err_d;
  logic                   flush;

  assign active = (state_q == S_LEN) ||
                  (state_q == S_PAYLOAD) ||
                  (state_q == S_CHECK);
  assign tmo    = active && (tcnt_q == TW'(TIMEOUT_CYCLES));

  // The FIFO head settles one cycle after a pop, so pops are spaced.
  assign accept = ((state_q == S_HUNT) && (n_q == '0)) ||
                  (active && !tmo);
  assign pop    = rx_valid && enable && accept && !pop_q;

  assign len_bad   = (rx_byte == 8'd0) ||
                     (rx_byte > 8'(CMD_DEPTH));
  assign tot_bytes = BCW'(len_q) * BCW'(NB);
  assign last_byte = (bcnt_q + 1'b1) == tot_bytes;
  assign last_entry = (rd_q + 1'b1) == n_q;
  assign xfer      = cmd_valid && cmd_ready;
  assign asm_cat   = {asm_q, rx_byte};
  assign asm_nx    = asm_cat[CMD_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ok_ev   = 1'b0;
    err_ev  = 1'b0;
    err_d   = 2'd0;
    flush   = 1'b0;
    if (!enable) begin
      state_d = S_HUNT;
      flush   = 1'b1;
    end else if (tmo) begin
      state_d = S_HUNT;
      err_ev  = 1'b1;
      err_d   = 2'd2;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        S_HUNT: begin
          if (pop && rx_byte == SOF_BYTE)
            state_d = S_LEN;
        end
        S_LEN: begin
          if (pop && len_bad) begin
            state_d = S_HUNT;
            err_ev  = 1'b1;
            err_d   = 2'd1;
            flush   = 1'b1;
          end else if (pop) begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (pop && last_byte) begin
`ifdef BLE_CMD_RX_CHKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DRAIN;
            ok_ev   = 1'b1;
`endif
          end
        end
        S_CHECK: begin
`ifdef BLE_CMD_RX_CHKSUM_EN
          if (pop && rx_byte == chk_q) begin
            state_d = S_DRAIN;
            ok_ev   = 1'b1;
          end else if (pop) begin
            state_d = S_HUNT;
            err_ev  = 1'b1;
            err_d   = 2'd3;
            flush   = 1'b1;
          end
`else
          state_d = S_HUNT;
`endif
        end
        S_DRAIN: begin
          if (xfer && last_entry) begin
            state_d = S_HUNT;
            flush   = 1'b1;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_comb begin
    rx_rd_en  = pop;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    cmd_data  = '0;
    if (state_q == S_DRAIN) begin
      cmd_valid = 1'b1;
      cmd_last  = last_entry;
      cmd_data  = stage[rd_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q  <= 1'b0;
      tcnt_q <= '0;
    end else begin
      pop_q <= pop;
      if (pop || !active)
        tcnt_q <= '0;
      else if (!tmo)
        tcnt_q <= tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      asm_q  <= '0;
      bcnt_q <= '0;
      sub_q  <= '0;
      wr_q   <= '0;
      for (int i = 0; i < CMD_DEPTH; i++)
        stage[i] <= '0;
    end else if (enable && !tmo && pop) begin
      if (state_q == S_LEN && !len_bad) begin
        len_q  <= rx_byte[LW-1:0];
        bcnt_q <= '0;
        sub_q  <= '0;
        wr_q   <= '0;
      end else if (state_q == S_PAYLOAD) begin
        asm_q  <= asm_nx;
        bcnt_q <= bcnt_q + 1'b1;
        if (sub_q == SW'(NB - 1)) begin
          stage[wr_q] <= asm_nx;
          wr_q        <= wr_q + 1'b1;
          sub_q       <= '0;
        end else begin
          sub_q <= sub_q + 1'b1;
        end
      end
    end
  end

`ifdef BLE_CMD_RX_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      chk_q <= '0;
    else if (enable && !tmo && pop) begin
      if (state_q == S_LEN)
        chk_q <= rx_byte;
      else if (state_q == S_PAYLOAD)
        chk_q <= chk_q ^ rx_byte;
    end
  end
`endif

  // n_q is the committed entry count; zero means staging is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q  <= '0;
      rd_q <= '0;
    end else if (flush) begin
      n_q  <= '0;
      rd_q <= '0;
    end else if (ok_ev) begin
      n_q  <= len_q;
      rd_q <= '0;
    end else if (xfer && !last_entry) begin
      rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      frame_ok  <= ok_ev;
      frame_err <= err_ev;
      if (ok_ev)
        err_code <= 2'd0;
      else if (err_ev)
        err_code <= err_d;
    end
  end

endmodule
